rv_plic_gateway: RTL and testbench
==================================

# rv_plic_gateway

Interrupt gateway and claim/complete responder for the RISC-V PLIC. It sits upstream of the per-target priority/threshold arbiter. It converts raw level- or edge-triggered sources into the pending vector `ip_o` that the arbiter consumes. It services the hart's claim and complete accesses using the ID the arbiter reported, and withholds further requests from a source until the claimed interrupt is completed.

## Interface
Parameters:
- `N_SOURCE`, 32: number of interrupt sources; ID 0 is reserved to mean "no interrupt".
- `SRCW`, `$clog2(N_SOURCE+1)`: local, ID width; not to be overridden.
- `DROPW`, 16: width of the saturating dropped-edge counter.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `src_i`  in  N_SOURCE  raw sources, already synchronized to `clk_i`.
- `le_i`  in  N_SOURCE  trigger mode per source: 1 = rising edge, 0 = level-high.
- `ip_o`  out  N_SOURCE  pending vector to the target arbiter.
- `ia_o`  out  N_SOURCE  in-service (claimed, not yet completed) vector.
- `claim_req_i`  in  1  one-cycle strobe for a claim-register read.
- `claim_id_i`  in  SRCW  ID offered by the target arbiter at the claim.
- `claim_valid_o`  out  1  read-data valid, one cycle after `claim_req_i`.
- `claim_data_o`  out  SRCW  claimed ID, or 0.
- `complete_req_i`  in  1  one-cycle strobe for a complete-register write.
- `complete_id_i`  in  SRCW  ID written by the hart.
- `clr_drop_i`  in  1  synchronous clear of `drop_cnt_o`.
- `drop_cnt_o`  out  DROPW  saturating count of coalesced edges.

## Operation
Per-source state: `src_q`, `epend`, `ip`, `ia`. All four are registered.
- `edge = src_i & ~src_q`.
- `req`:
  - edge mode: `req = edge | epend`.
  - level mode: `req = src_i`.
- `set_ip = req & ~ip & ~ia`: a source is forwarded only when it is neither pending nor in service.
- `claim_hit[i]`: `claim_req_i` is high, `claim_id_i == i+1`, and `ip[i]` is set.
  - On a hit: `ip[i]` clears and `ia[i]` sets.
- `complete_hit[i]`: `complete_req_i` is high, `complete_id_i == i+1`, and `ia[i]` is set.
  - On a hit: `ia[i]` clears.
- Next-state equations:
  - `ip <= (ip & ~claim_hit) | set_ip`.
  - `ia <= (ia & ~complete_hit) | claim_hit`.
- `epend <= le_i & (epend | edge) & ~set_ip`. In level mode `epend` is held at 0, and changing `le_i` discards any stored edge.
- Dropped edge: an edge that arrives while `epend` is already 1 and `set_ip` is 0 is coalesced. The drop counter increments by at most 1 per cycle, saturates at all-ones, and `clr_drop_i` takes priority over an increment.
- Invariant: `ip[i] & ia[i]` is never 1.
- Ignored requests:
  - a claim of ID 0, an ID greater than `N_SOURCE`, or a non-pending source changes no state and returns 0;
  - a complete of ID 0, an out-of-range ID, or an ID not in service is ignored.
- Level mode: deasserting `src_i` does not retract a set `ip`. Only a claim clears it.
- Simultaneous claim and complete in one cycle (same or different IDs): both are applied independently per the equations above.

## Timing
- Reset (async assert, deassert synchronous to `clk_i`): every register and every output is 0.
- `src_i` change → `ip_o` updated one cycle later (registered). An edge at cycle t gives `ip_o` high at t+1.
- `claim_req_i` at cycle t:
  - `claim_valid_o` is high at t+1 for exactly one cycle;
  - `claim_data_o` is the ID at t+1 and 0 otherwise;
  - `ip_o`/`ia_o` reflect the claim at t+1.
- `complete_req_i` at t → `ia_o` clears at t+1. A still-high level source, or a stored `epend`, re-asserts `ip_o` at t+2.
- Back-to-back claims are legal every cycle; no backpressure exists.

## Structure
- Package `rv_plic_pkg` holds:
  - the `N_SOURCE` default;
  - the SRCW/ID computation;
  - the reserved-ID-0 constant;
  - `DROPW`.
- One sub-module `rv_plic_gw_src` implements a single source slice: `src_q`, `epend`, `ip`, `ia`, and the `drop` pulse. The top instantiates it `N_SOURCE` times and adds:
  - the claim/complete ID decode;
  - the claim response register;
  - an OR-reduce of the drop pulses feeding the counter.

## Test plan
- Level source 3 high at cycle 0 → `ip_o[3]`=1 at cycle 1. Claim ID 4 → `claim_data_o`=4, `ip_o[3]`=0, `ia_o[3]`=1. Complete ID 4 with the source still high → `ip_o[3]`=1 two cycles after the complete.
- Edge source 0: pulse, claim ID 1, then two more pulses before completing → one stored edge, `drop_cnt_o`=1. Complete → `ip_o[0]` re-asserts, and a second complete → no further `ip`.
- Claim ID 0, then ID 33 (`N_SOURCE`=32), then ID 5 while source 4 is not pending → `claim_data_o`=0 in each case, no state change.
- In one cycle, complete ID 2 (in service) and claim ID 7 (pending) → at the next cycle `ia_o[1]`=0, `ia_o[6]`=1, `claim_data_o`=7.
- Assert `rst_ni` low mid-service with sources active → all outputs 0 asynchronously. After release, level sources re-pend after 1 cycle and stored edges are lost.
- Force 70000 coalesced edges → `drop_cnt_o` saturates at 0xFFFF. `clr_drop_i` together with a drop → 0.

Source files
------------

// File: rtl/rv_plic_gateway_pkg.sv
// Shared constants for the PLIC gateway: default source count, ID width, reserved ID.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package rv_plic_pkg;

    // Default number of interrupt sources; IDs run 1..N, 0 means "no interrupt".
    localparam int DEF_N_SOURCE = 32;

    // Width of the saturating dropped-edge counter.
    localparam int DEF_DROPW = 16;

    // Reserved ID returned when a claim finds nothing to hand out.
    localparam int ID_NONE = 0;

    // ID width must hold N_SOURCE itself, hence the +1.
    function automatic int id_width(input int n_source);
        return $clog2(n_source + 1);
    endfunction

    localparam int DEF_SRCW = id_width(DEF_N_SOURCE);

endpackage

// File: rtl/rv_plic_gateway_if.sv
// Claim/complete access bundle between the hart-side register block and the gateway.
// Latency: claim read data returns one cycle after the claim strobe.
// Backpressure: none; strobes are accepted every cycle.
interface rv_plic_gateway_if #(
    parameter int SRCW = rv_plic_pkg::DEF_SRCW
);
    logic            claim_req_i;
    logic [SRCW-1:0] claim_id_i;
    logic            claim_valid_o;
    logic [SRCW-1:0] claim_data_o;
    logic            complete_req_i;
    logic [SRCW-1:0] complete_id_i;

    // Gateway side.
    modport slave (
        input  claim_req_i,
        input  claim_id_i,
        input  complete_req_i,
        input  complete_id_i,
        output claim_valid_o,
        output claim_data_o
    );

    // Hart / register-block side.
    modport master (
        output claim_req_i,
        output claim_id_i,
        output complete_req_i,
        output complete_id_i,
        input  claim_valid_o,
        input  claim_data_o
    );
endinterface

// File: rtl/rv_plic_gw_src.sv
// One interrupt source slice: edge/level gateway with pending and in-service state.
// Latency: source change to pending is one cycle; claim/complete take effect next cycle.
// Backpressure: none; a source is held off while pending or in service, extra edges coalesce.
module rv_plic_gw_src (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_src,
    input  logic i_le,
    input  logic i_claim_hit,
    input  logic i_complete_hit,
    output logic o_ip,
    output logic o_ia,
    output logic o_drop
);

    logic r_src_q;
    logic r_epend;
    logic r_ip;
    logic r_ia;

    logic w_edge;
    logic w_req;
    logic w_set_ip;

    // Request generation: edge mode forwards a fresh or stored edge, level mode the raw line.
    always_comb begin
        w_edge   = i_src & ~r_src_q;
        w_req    = i_le ? (w_edge | r_epend) : i_src;
        w_set_ip = w_req & ~r_ip & ~r_ia;
    end

    // An edge landing on an already stored edge that cannot be forwarded is lost.
    assign o_drop = w_edge & r_epend & ~w_set_ip;

    // Source history, stored edge, pending and in-service state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src_q <= 1'b0;
            r_epend <= 1'b0;
            r_ip    <= 1'b0;
            r_ia    <= 1'b0;
        end else begin
            r_src_q <= i_src;
            // Leaving edge mode discards any stored edge.
            r_epend <= i_le & (r_epend | w_edge) & ~w_set_ip;
            r_ip    <= (r_ip & ~i_claim_hit) | w_set_ip;
            r_ia    <= (r_ia & ~i_complete_hit) | i_claim_hit;
        end
    end

    assign o_ip = r_ip;
    assign o_ia = r_ia;

endmodule

// File: rtl/rv_plic_gateway.sv
// PLIC gateway: turns raw sources into a pending vector and answers claim/complete accesses.
// Latency: claim data one cycle after the strobe; source to pending one cycle.
// Backpressure: none; claims and completes may arrive every cycle.
module rv_plic_gateway
    import rv_plic_pkg::*;
#(
    parameter int N_SOURCE = DEF_N_SOURCE,
    parameter int DROPW    = DEF_DROPW
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] le_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] ia_o,
    rv_plic_gateway_if.slave    bus,
    input  logic                clr_drop_i,
    output logic [DROPW-1:0]    drop_cnt_o
);

    localparam int SRCW = id_width(N_SOURCE);

    logic [N_SOURCE-1:0] w_ip;
    logic [N_SOURCE-1:0] w_ia;
    logic [N_SOURCE-1:0] w_claim_hit;
    logic [N_SOURCE-1:0] w_complete_hit;
    logic [N_SOURCE-1:0] w_drop_vec;
    logic                w_drop;

    logic                r_claim_vld;
    logic [SRCW-1:0]     r_claim_dat;
    logic [DROPW-1:0]    r_drop_cnt;

    // ID decode: source g answers to ID g+1, so ID 0 and IDs above N_SOURCE never hit.
    // A claim only hits a pending source, a complete only an in-service one.
    for (genvar g = 0; g < N_SOURCE; g++) begin : g_src
        assign w_claim_hit[g]    = bus.claim_req_i &&
                                   (bus.claim_id_i == SRCW'(g + 1)) && w_ip[g];
        assign w_complete_hit[g] = bus.complete_req_i &&
                                   (bus.complete_id_i == SRCW'(g + 1)) && w_ia[g];

        rv_plic_gw_src u_src (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .i_src          (src_i[g]),
            .i_le           (le_i[g]),
            .i_claim_hit    (w_claim_hit[g]),
            .i_complete_hit (w_complete_hit[g]),
            .o_ip           (w_ip[g]),
            .o_ia           (w_ia[g]),
            .o_drop         (w_drop_vec[g])
        );
    end

    assign w_drop = |w_drop_vec;

    // Claim response: valid follows every strobe, data is the ID only when it hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_claim_vld <= 1'b0;
            r_claim_dat <= SRCW'(ID_NONE);
        end else begin
            r_claim_vld <= bus.claim_req_i;
            r_claim_dat <= (|w_claim_hit) ? bus.claim_id_i : SRCW'(ID_NONE);
        end
    end

    // Dropped-edge counter: clear wins over increment, saturates at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (clr_drop_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROPW{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign ip_o              = w_ip;
    assign ia_o              = w_ia;
    assign bus.claim_valid_o = r_claim_vld;
    assign bus.claim_data_o  = r_claim_dat;
    assign drop_cnt_o        = r_drop_cnt;

endmodule

// File: tb/tb_rv_plic_gateway.sv
// Directed self-checking bench for rv_plic_gateway (N_SOURCE = 32).
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: none exercised; the gateway has none.
module tb_rv_plic_gateway;

    localparam int IDW = 6;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] src_i;
    logic [31:0] le_i;
    logic [31:0] ip_o;
    logic [31:0] ia_o;
    logic        clr_drop_i;
    logic [15:0] drop_cnt_o;

    int errors = 0;
    int checks = 0;

    rv_plic_gateway_if #(.SRCW(IDW)) bus ();

    rv_plic_gateway dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .src_i      (src_i),
        .le_i       (le_i),
        .ip_o       (ip_o),
        .ia_o       (ia_o),
        .bus        (bus),
        .clr_drop_i (clr_drop_i),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_claim(input int id);
        bus.claim_req_i = 1'b1;
        bus.claim_id_i  = IDW'(id);
        tick();
        bus.claim_req_i = 1'b0;
        bus.claim_id_i  = '0;
    endtask

    task automatic do_complete(input int id);
        bus.complete_req_i = 1'b1;
        bus.complete_id_i  = IDW'(id);
        tick();
        bus.complete_req_i = 1'b0;
        bus.complete_id_i  = '0;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni             = 1'b0;
        src_i              = '0;
        le_i               = 32'h0000_0301;   // sources 0, 8, 9 edge mode
        clr_drop_i         = 1'b0;
        bus.claim_req_i    = 1'b0;
        bus.claim_id_i     = '0;
        bus.complete_req_i = 1'b0;
        bus.complete_id_i  = '0;
        tick();
        tick();
        chk("rst_ip",    ip_o, 32'h0);
        chk("rst_ia",    ia_o, 32'h0);
        chk("rst_cvld",  32'(bus.claim_valid_o), 32'h0);
        chk("rst_cdat",  32'(bus.claim_data_o), 32'h0);
        chk("rst_drop",  32'(drop_cnt_o), 32'h0);
        rst_ni = 1'b1;

        // Level source 3 -> ID 4.
        src_i[3] = 1'b1;
        tick();
        chk("lvl_pend", ip_o, 32'h8);
        do_claim(4);
        chk("lvl_cvld", 32'(bus.claim_valid_o), 32'h1);
        chk("lvl_cdat", 32'(bus.claim_data_o), 32'd4);
        chk("lvl_claim_ip", ip_o, 32'h0);
        chk("lvl_claim_ia", ia_o, 32'h8);
        tick();
        chk("lvl_cvld_1cyc", 32'(bus.claim_valid_o), 32'h0);
        chk("lvl_cdat_zero", 32'(bus.claim_data_o), 32'h0);
        chk("lvl_held_off", ip_o, 32'h0);
        do_complete(4);
        chk("lvl_cmpl_ia", ia_o, 32'h0);
        chk("lvl_cmpl_ip_t1", ip_o, 32'h0);
        tick();
        chk("lvl_repend_t2", ip_o, 32'h8);
        src_i[3] = 1'b0;
        tick();
        chk("lvl_no_retract", ip_o, 32'h8);
        do_claim(4);
        do_complete(4);
        tick();
        chk("lvl_clean_ip", ip_o, 32'h0);
        chk("lvl_clean_ia", ia_o, 32'h0);

        // Edge source 0 -> ID 1, with one stored and one coalesced edge.
        src_i[0] = 1'b1;
        tick();
        src_i[0] = 1'b0;
        chk("edge_pend", ip_o, 32'h1);
        do_claim(1);
        chk("edge_cdat", 32'(bus.claim_data_o), 32'd1);
        chk("edge_claim_ia", ia_o, 32'h1);
        src_i[0] = 1'b1; tick();
        src_i[0] = 1'b0; tick();
        src_i[0] = 1'b1; tick();
        src_i[0] = 1'b0; tick();
        chk("edge_drop1", 32'(drop_cnt_o), 32'd1);
        chk("edge_held_ip", ip_o, 32'h0);
        do_complete(1);
        chk("edge_cmpl_ia", ia_o, 32'h0);
        chk("edge_cmpl_ip_t1", ip_o, 32'h0);
        tick();
        chk("edge_stored_repend", ip_o, 32'h1);
        do_claim(1);
        do_complete(1);
        tick();
        tick();
        chk("edge_no_more_ip", ip_o, 32'h0);
        chk("edge_no_more_ia", ia_o, 32'h0);

        // Ignored claims and completes leave state untouched.
        src_i[1] = 1'b1;
        src_i[6] = 1'b1;
        tick();
        chk("two_pend", ip_o, 32'h42);
        do_claim(2);
        chk("claim2_dat", 32'(bus.claim_data_o), 32'd2);
        chk("claim2_ip", ip_o, 32'h40);
        chk("claim2_ia", ia_o, 32'h2);
        do_claim(0);
        chk("claim0_vld", 32'(bus.claim_valid_o), 32'h1);
        chk("claim0_dat", 32'(bus.claim_data_o), 32'h0);
        chk("claim0_ip", ip_o, 32'h40);
        chk("claim0_ia", ia_o, 32'h2);
        do_claim(33);
        chk("claim33_dat", 32'(bus.claim_data_o), 32'h0);
        chk("claim33_ip", ip_o, 32'h40);
        chk("claim33_ia", ia_o, 32'h2);
        do_claim(5);
        chk("claim5_dat", 32'(bus.claim_data_o), 32'h0);
        chk("claim5_ip", ip_o, 32'h40);
        chk("claim5_ia", ia_o, 32'h2);
        do_complete(0);
        do_complete(3);
        do_complete(40);
        chk("bad_cmpl_ia", ia_o, 32'h2);
        chk("bad_cmpl_ip", ip_o, 32'h40);

        // Complete ID 2 and claim ID 7 in the same cycle.
        bus.complete_req_i = 1'b1;
        bus.complete_id_i  = IDW'(2);
        bus.claim_req_i    = 1'b1;
        bus.claim_id_i     = IDW'(7);
        tick();
        bus.complete_req_i = 1'b0;
        bus.complete_id_i  = '0;
        bus.claim_req_i    = 1'b0;
        bus.claim_id_i     = '0;
        chk("dual_ia", ia_o, 32'h40);
        chk("dual_cdat", 32'(bus.claim_data_o), 32'd7);
        chk("dual_ip", ip_o, 32'h0);
        tick();
        chk("dual_repend", ip_o, 32'h2);

        // Build service state plus a stored edge, then reset asynchronously.
        src_i[0] = 1'b1;
        tick();
        src_i[0] = 1'b0;
        chk("pre_rst_ip", ip_o, 32'h3);
        do_claim(1);
        chk("pre_rst_ia", ia_o, 32'h41);
        src_i[0] = 1'b1;
        do_claim(2);
        src_i[0] = 1'b0;
        chk("pre_rst_cdat", 32'(bus.claim_data_o), 32'd2);
        chk("pre_rst_ia2", ia_o, 32'h43);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_ip",   ip_o, 32'h0);
        chk("arst_ia",   ia_o, 32'h0);
        chk("arst_cvld", 32'(bus.claim_valid_o), 32'h0);
        chk("arst_cdat", 32'(bus.claim_data_o), 32'h0);
        chk("arst_drop", 32'(drop_cnt_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_lvl", ip_o, 32'h42);
        chk("post_rst_ia", ia_o, 32'h0);
        tick();
        chk("post_rst_edge_lost", ip_o, 32'h42);

        // Drop counter: sources 8/9 in service, alternating edges give one drop per cycle.
        src_i[8] = 1'b1;
        src_i[9] = 1'b1;
        tick();
        src_i[8] = 1'b0;
        src_i[9] = 1'b0;
        chk("drop_setup_ip", ip_o, 32'h342);
        do_claim(9);
        chk("claim9_dat", 32'(bus.claim_data_o), 32'd9);
        do_claim(10);
        chk("claim10_dat", 32'(bus.claim_data_o), 32'd10);
        chk("drop_setup_ia", ia_o, 32'h300);
        for (int k = 0; k < 10; k++) begin
            src_i[8] = (k % 2 == 0);
            src_i[9] = (k % 2 == 1);
            tick();
        end
        chk("drop_cnt8", 32'(drop_cnt_o), 32'd8);
        for (int k = 10; k < 65600; k++) begin
            src_i[8] = (k % 2 == 0);
            src_i[9] = (k % 2 == 1);
            tick();
        end
        chk("drop_sat", 32'(drop_cnt_o), 32'hFFFF);
        src_i[8]   = 1'b1;
        src_i[9]   = 1'b0;
        clr_drop_i = 1'b1;
        tick();
        clr_drop_i = 1'b0;
        chk("drop_clr_wins", 32'(drop_cnt_o), 32'h0);
        src_i[8] = 1'b0;
        src_i[9] = 1'b1;
        tick();
        chk("drop_resume", 32'(drop_cnt_o), 32'h1);
        src_i[9] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
